// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller.
// Produces t1..t4 phase strobes and w1..w3 beat levels, with short/long/stop/step beat control.
module beat_timing_gen #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned STEP_EN = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic step,
  input  logic short,
  input  logic long,
  input  logic stop,
  output logic t1,
  output logic t2,
  output logic t3,
  output logic t4,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic running
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] B_W1 = 2'd0;
  localparam logic [1:0] B_W2 = 2'd1;
  localparam logic [1:0] B_W3 = 2'd2;

  logic [0:0]    r_state, w_state_n;
  logic [1:0]    r_phase, w_phase_n;
  logic [DW-1:0] r_div,   w_div_n;
  logic [1:0]    r_beat,  w_beat_n;
  logic          r_start_d;

  logic       w_start_edge;
  logic       w_beat_end;
  logic       w_halt;
  logic [1:0] w_beat_sel;

  assign w_start_edge = start & ~r_start_d;
  assign w_beat_end   = (r_state == S_RUN) && (r_phase == 2'd3) && (r_div == DIV_LAST);
  assign w_halt       = stop | ((STEP_EN != 0) & step);

  // Beat sequencing: short wins in w1, long only matters in w2, w3 always returns to w1.
  always_comb begin
    w_beat_sel = B_W1;
    case (r_beat)
      B_W1:    w_beat_sel = short ? B_W1 : B_W2;
      B_W2:    w_beat_sel = long  ? B_W3 : B_W1;
      default: w_beat_sel = B_W1;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_div_n   = r_div;
    w_beat_n  = r_beat;
    if (r_state == S_IDLE) begin
      if (w_start_edge) begin
        w_state_n = S_RUN;
        w_phase_n = 2'd0;
        w_div_n   = '0;
      end
    end else if (r_div == DIV_LAST) begin
      w_div_n   = '0;
      w_phase_n = r_phase + 2'd1;
      if (w_beat_end) begin
        w_beat_n = w_beat_sel;
        if (w_halt) w_state_n = S_IDLE;
      end
    end else begin
      w_div_n = r_div + DW'(1);
    end
  end

  // Outputs are decoded from next state so they line up with the state registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_phase   <= 2'd0;
      r_div     <= '0;
      r_beat    <= B_W1;
      r_start_d <= start;
      t1        <= 1'b0;
      t2        <= 1'b0;
      t3        <= 1'b0;
      t4        <= 1'b0;
      w1        <= 1'b0;
      w2        <= 1'b0;
      w3        <= 1'b0;
      running   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_div     <= w_div_n;
      r_beat    <= w_beat_n;
      r_start_d <= start;
      t1        <= (w_state_n == S_RUN) && (w_phase_n == 2'd0);
      t2        <= (w_state_n == S_RUN) && (w_phase_n == 2'd1);
      t3        <= (w_state_n == S_RUN) && (w_phase_n == 2'd2);
      t4        <= (w_state_n == S_RUN) && (w_phase_n == 2'd3);
      w1        <= (w_state_n == S_RUN) && (w_beat_n == B_W1);
      w2        <= (w_state_n == S_RUN) && (w_beat_n == B_W2);
      w3        <= (w_state_n == S_RUN) && (w_beat_n == B_W3);
      running   <= (w_state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed bench: CLK_DIV=1/STEP_EN=0 instance for sequencing, CLK_DIV=3/STEP_EN=1 instance for divider and step.
module tb_beat_timing_gen;

  logic clk = 1'b0;
  logic clr, start, step, short, long, stop;
  logic t1a, t2a, t3a, t4a, w1a, w2a, w3a, runa;
  logic t1b, t2b, t3b, t4b, w1b, w2b, w3b, runb;
  logic [7:0] o1, o2;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  beat_timing_gen #(.CLK_DIV(1), .STEP_EN(0)) dut (
    .clk(clk), .clr(clr), .start(start), .step(step), .short(short), .long(long), .stop(stop),
    .t1(t1a), .t2(t2a), .t3(t3a), .t4(t4a), .w1(w1a), .w2(w2a), .w3(w3a), .running(runa)
  );

  beat_timing_gen #(.CLK_DIV(3), .STEP_EN(1)) dut_div (
    .clk(clk), .clr(clr), .start(start), .step(step), .short(short), .long(long), .stop(stop),
    .t1(t1b), .t2(t2b), .t3(t3b), .t4(t4b), .w1(w1b), .w2(w2b), .w3(w3b), .running(runb)
  );

  assign o1 = {runa, w3a, w2a, w1a, t4a, t3a, t2a, t1a};
  assign o2 = {runb, w3b, w2b, w1b, t4b, t3b, t2b, t1b};

  // {running, w3, w2, w1, t4, t3, t2, t1}; w==0 means idle
  function automatic logic [7:0] ev(input int w, input int p);
    if (w == 0) return 8'h00;
    return {1'b1, w == 3, w == 2, w == 1, p == 3, p == 2, p == 1, p == 0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input string tag, input int w);
    for (int p = 0; p < 4; p++) begin
      tick();
      chk(tag, o1, ev(w, p));
    end
  endtask

  task automatic run_beat_div(input string tag, input int w);
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < 3; d++) begin
        tick();
        chk(tag, o2, ev(w, p));
      end
  endtask

  initial begin
    clr = 1; start = 0; step = 0; short = 0; long = 0; stop = 0;
    tick();
    chk("reset_a", o1, 8'h00);
    chk("reset_b", o2, 8'h00);
    clr = 0;
    tick();
    chk("idle_no_start", o1, 8'h00);

    // basic sequence w1, w2, w1; start stays high through RUN
    start = 1;
    run_beat("basic_w1", 1);
    run_beat("basic_w2", 2);
    run_beat("basic_w1b", 1);

    // short held across a full w1: only the beat-end sample counts
    short = 1;
    run_beat("short_w1", 1);
    short = 0;
    run_beat("short_w2", 2);

    // long at w2 end inserts w3; long at w3/w1 end is ignored
    long = 1;
    run_beat("long_w3", 3);
    run_beat("long_w1", 1);
    long = 0;
    run_beat("long_in_w1_w2", 2);
    run_beat("after_w2_w1", 1);

    // stop at w1 end, held start does not resume, new edge resumes at w2
    stop = 1;
    tick(); chk("stop_idle", o1, 8'h00);
    stop = 0;
    tick(); chk("held_start_1", o1, 8'h00);
    tick(); chk("held_start_2", o1, 8'h00);
    start = 0;
    tick(); chk("start_low", o1, 8'h00);
    start = 1;
    run_beat("resume_w2", 2);

    // stop together with long at w2 end: w3 is stored for resume
    stop = 1; long = 1;
    tick(); chk("stop_long_idle", o1, 8'h00);
    stop = 0; long = 0; start = 0;
    tick(); chk("stop_long_idle2", o1, 8'h00);
    start = 1;
    run_beat("resume_w3", 3);
    run_beat("after_w3", 1);

    // clr in phase 2 of w2; held start must not fire, resume forced to w1
    tick(); chk("clr_pre_p0", o1, ev(2, 0));
    tick(); chk("clr_pre_p1", o1, ev(2, 1));
    tick(); chk("clr_pre_p2", o1, ev(2, 2));
    clr = 1;
    tick(); chk("clr_mid_beat", o1, 8'h00);
    clr = 0;
    tick(); chk("clr_held_start", o1, 8'h00);
    start = 0;
    tick(); chk("clr_start_low", o1, 8'h00);
    start = 1;
    run_beat("clr_resume_w1", 1);

    // divider and step on the second instance
    clr = 1; start = 0;
    tick();
    chk("div_reset", o2, 8'h00);
    clr = 0; step = 1;
    tick(); chk("div_idle", o2, 8'h00);
    start = 1;
    run_beat_div("div_w1", 1);
    tick();
    chk("step_halt_1", o2, 8'h00);
    chk("step_ignored_a", o1, ev(2, 0));
    start = 0;
    tick(); chk("step_idle", o2, 8'h00);
    start = 1;
    run_beat_div("div_w2", 2);
    tick();
    chk("step_halt_2", o2, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
- Timing generator directly upstream of the hardwired controller.
- Produces the beat signals w1/w2/w3 and the per-beat phase strobe t3 that the controller consumes.
- Consumes the controller's short/long/stop requests to shorten, lengthen or halt the beat sequence.
- The start push-button resumes execution after a halt.

Parameters:
- CLK_DIV, 1, clk cycles per phase (≥1); one beat = 4 phases = 4*CLK_DIV cycles.
- STEP_EN, 0, if 1 the step input is honoured (halt after each beat).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- start  in  1  start button level, already debounced; rising edge resumes run
- step  in  1  single-beat mode level (ignored when STEP_EN=0)
- short  in  1  controller request: current beat is the last of the instruction cycle
- long  in  1  controller request: insert w3 after w2
- stop  in  1  controller request: halt after the current beat
- t1  out  1  phase 0 strobe
- t2  out  1  phase 1 strobe
- t3  out  1  phase 2 strobe (controller latch edge)
- t4  out  1  phase 3 strobe
- w1  out  1  beat 1 active
- w2  out  1  beat 2 active
- w3  out  1  beat 3 active
- running  out  1  generator in RUN state

Behaviour:
- All outputs registered.
- On clr (sampled at the clk edge):
  - state=IDLE, phase=0, div counter=0, next beat=w1.
  - All outputs 0.
  - Start-edge history register loads the current start level, so a held button does not fire.
- States: IDLE, RUN.
- IDLE:
  - t1..t4, w1..w3 = 0; running=0.
  - A start rising edge (start=1, previous=0) moves to RUN.
  - In the first RUN cycle: phase 0, t1=1, and the stored next beat (w1 after reset/clr) is asserted.
- RUN:
  - Div counter counts 0..CLK_DIV-1; phase advances 0→1→2→3 on div wrap.
  - Exactly one of t1..t4 is high, matching the phase.
  - Exactly one of w1..w3 is high for the whole beat.
- Beat end is the last cycle of phase 3. short/long/stop/step are sampled only in that cycle. Next beat:
  - w1: short=1 → w1; else w2 (long ignored in w1).
  - w2: long=1 → w3; else w1 (short in w2 → w1).
  - w3: → w1.
  - Both short and long in w1: short wins.
- Halt:
  - stop=1, or (STEP_EN=1 and step=1), at beat end → IDLE next cycle.
  - The computed next beat is stored and resumed on the next start edge, starting at phase 0.
  - When stop coincides with short/long, the beat selection still applies.
- start edges while in RUN are ignored.
- Control inputs outside the beat-end cycle have no effect.
- clr mid-beat: IDLE on the next cycle, outputs 0, resume beat forced to w1.
- In the cycle after a halt, outputs are all 0 (no partial beat).

Test Plan:
- Basic sequence: CLK_DIV=1, clr pulse, start 0→1, short=long=stop=0 → w1 for 4 cycles, then w2 for 4, then w1 again; t3=1 on the 3rd cycle of each beat; running=1.
- Short: short=1 held during w1 end cycle → w1 repeats (8 consecutive w1 cycles), w2 never asserted.
- Long: long=1 at w2 end → w3 for 4 cycles then w1; long=1 at w1 end alone → w2 (no w3).
- Stop and resume:
  - stop=1 at w1 end → cycle after: running=0, all w/t=0.
  - start held high → no resume.
  - start 0→1 → w2, t1 in the first cycle.
- Reset: clr asserted in phase 2 of w2 → next cycle all outputs 0.
- Step and divider: start edge after clr → w1. With CLK_DIV=3, t1..t4 each last 3 cycles (beat=12). With STEP_EN=1, step=1 → halts after every beat.
